// File: rtl/axi_rd_resp_gen_pkg.sv
// Shared types for the AXI read responder: burst/state enums, RRESP codes, beat layout.
// The packed beat width tracks `S_R_DATASIZE (defaults to ID 8 + DATA 32 + 3).
`ifndef S_R_DATASIZE
`define S_R_DATASIZE 43
`endif

package axi_rd_resp_gen_pkg;

    localparam int unsigned PKG_ID_W   = 8;
    localparam int unsigned PKG_DATA_W = 32;
    localparam int unsigned S_R_W      = `S_R_DATASIZE;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    typedef struct packed {
        logic [PKG_ID_W-1:0]   rid;
        logic [PKG_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rlast;
    } beat_t;

endpackage

// File: rtl/axi_rd_resp_gen_if.sv
// AXI AR channel bundle between a read master and the slave-side responder.
interface axi_rd_resp_gen_if #(
    parameter int unsigned ID_W   = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 4
);
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [LEN_W-1:0]  ARLEN;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARBURST, ARVALID,
        input  ARREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARBURST, ARVALID,
        output ARREADY
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Next beat address for FIXED/INCR/WRAP bursts; purely combinational.
// WRAP arithmetic exists only when RD_WRAP_BURST_EN is defined.
module axi_burst_addr_gen
    import axi_rd_resp_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4
) (
    input  logic [ADDR_W-1:0] addr,
    input  burst_e            burst,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] next_addr
);
    localparam int unsigned BYTES    = DATA_W / 8;
    localparam int unsigned WORD_LSB = $clog2(BYTES);

    logic [ADDR_W-1:0] incr_c;
    assign incr_c = addr + ADDR_W'(BYTES);

`ifdef RD_WRAP_BURST_EN
    // Window is (len+1) beats; the low bits roll over inside it, the high bits stay.
    logic [ADDR_W-1:0] wrap_mask_c;
    logic [ADDR_W-1:0] wrap_c;
    assign wrap_mask_c = ((ADDR_W'(len) + ADDR_W'(1)) << WORD_LSB) - ADDR_W'(1);
    assign wrap_c      = (addr & ~wrap_mask_c) | (incr_c & wrap_mask_c);
`else
    logic unused_len;
    assign unused_len = ^len;
`endif

    always_comb begin
        next_addr = addr;
        case (burst)
            BURST_INCR: next_addr = incr_c;
`ifdef RD_WRAP_BURST_EN
            BURST_WRAP: next_addr = wrap_c;
`endif
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_rd_resp_gen.sv
// Slave-side AXI read responder: AR request -> SRAM reads -> {rid,rdata,rresp,rlast} FIFO pushes.
// Optional WRAP burst support under RD_WRAP_BURST_EN; otherwise WRAP answers with SLVERR beats.
module axi_rd_resp_gen
    import axi_rd_resp_gen_pkg::*;
#(
    parameter int unsigned ID_W   = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned MEM_AW = 14
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    axi_rd_resp_gen_if.slave         ar,
    output logic                     mem_ce,
    output logic [MEM_AW-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [ID_W+DATA_W+2:0]   wdata,
    output logic                     wpush,
    input  logic                     wfull
);
    localparam int unsigned BYTES    = DATA_W / 8;
    localparam int unsigned WORD_LSB = $clog2(BYTES);
    localparam int unsigned CNT_W    = LEN_W + 1;
    localparam int unsigned BEAT_W   = ID_W + DATA_W + 3;

    state_e             state_q;
    logic               arready_q;
    logic [ID_W-1:0]    id_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    burst_e             burst_q;
    logic [CNT_W-1:0]   issued_q;
    logic [CNT_W-1:0]   pushed_q;
    logic               rvalid_q;
    logic               hold_valid_q;
    logic [BEAT_W-1:0]  hold_q;

    logic [ADDR_W-1:0]  next_addr_c;
    logic               req_ok_c;
    logic               issue_c;
    logic               last_c;
    logic               push_c;
    logic               done_c;
    logic [BEAT_W-1:0]  beat_mem_c;
    logic [BEAT_W-1:0]  beat_err_c;
    logic [BEAT_W-1:0]  wdata_c;

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .addr      (addr_q),
        .burst     (burst_q),
        .len       (len_q),
        .next_addr (next_addr_c)
    );

    // Request legality: reserved bursts, and WRAP unless enabled with len of 1/3/7/15.
    always_comb begin
        req_ok_c = 1'b0;
        case (burst_e'(ar.ARBURST))
            BURST_FIXED, BURST_INCR: req_ok_c = 1'b1;
`ifdef RD_WRAP_BURST_EN
            BURST_WRAP: req_ok_c = (ar.ARLEN != '0) &&
                                   ((ar.ARLEN & (ar.ARLEN + LEN_W'(1))) == '0);
`endif
            default:                 req_ok_c = 1'b0;
        endcase
    end

    assign issue_c    = (state_q == ST_READ) && (issued_q <= CNT_W'(len_q)) &&
                        !hold_valid_q && !wfull;
    assign last_c     = (pushed_q == CNT_W'(len_q));
    assign beat_mem_c = {id_q, mem_rdata, RRESP_OKAY, last_c};
    assign beat_err_c = {id_q, DATA_W'(0), RRESP_SLVERR, last_c};

    // Push source: SLVERR beat, held beat, or the memory beat landing this cycle.
    always_comb begin
        push_c  = 1'b0;
        wdata_c = '0;
        if (state_q == ST_ERR) begin
            push_c  = !wfull;
            wdata_c = beat_err_c;
        end else if (state_q == ST_READ) begin
            if (hold_valid_q) begin
                push_c  = !wfull;
                wdata_c = hold_q;
            end else if (rvalid_q) begin
                push_c  = !wfull;
                wdata_c = beat_mem_c;
            end
        end
    end

    assign done_c     = push_c && wdata_c[0];
    assign wpush      = push_c;
    assign wdata      = push_c ? wdata_c : '0;
    assign mem_ce     = issue_c;
    assign mem_addr   = addr_q[WORD_LSB +: MEM_AW];
    assign ar.ARREADY = arready_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= ST_IDLE;
            arready_q    <= 1'b0;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            burst_q      <= BURST_FIXED;
            issued_q     <= '0;
            pushed_q     <= '0;
            rvalid_q     <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            rvalid_q <= issue_c;
            if (issue_c) begin
                addr_q   <= next_addr_c;
                issued_q <= issued_q + CNT_W'(1);
            end
            if (push_c) begin
                pushed_q <= pushed_q + CNT_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (ar.ARVALID && arready_q) begin
                        id_q      <= ar.ARID;
                        addr_q    <= ar.ARADDR;
                        len_q     <= ar.ARLEN;
                        burst_q   <= burst_e'(ar.ARBURST);
                        issued_q  <= '0;
                        pushed_q  <= '0;
                        arready_q <= 1'b0;
                        state_q   <= req_ok_c ? ST_READ : ST_ERR;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                ST_READ: begin
                    // A beat landing while the FIFO is full parks in the hold register.
                    if (hold_valid_q) begin
                        if (!wfull) begin
                            hold_valid_q <= 1'b0;
                        end
                    end else if (rvalid_q && wfull) begin
                        hold_q       <= beat_mem_c;
                        hold_valid_q <= 1'b1;
                    end
                    if (done_c) begin
                        state_q   <= ST_IDLE;
                        arready_q <= 1'b1;
                    end
                end
                ST_ERR: begin
                    if (done_c) begin
                        state_q   <= ST_IDLE;
                        arready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    arready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_resp_gen.sv
// Bench for axi_rd_resp_gen: request table plus reset-abort sequence, scoreboarded beats.
module tb_axi_rd_resp_gen;
    import axi_rd_resp_gen_pkg::*;

    localparam int unsigned ID_W   = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned MEM_AW = 14;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    mem_ce;
    logic [MEM_AW-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_rdata = '0;
    logic [ID_W+DATA_W+2:0]  wdata;
    logic                    wpush;
    logic                    wfull = 1'b0;

    axi_rd_resp_gen_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) ar_if ();

    axi_rd_resp_gen #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MEM_AW(MEM_AW)
    ) dut (
        .ACLK      (clk),
        .ARESETn   (rst_n),
        .ar        (ar_if),
        .mem_ce    (mem_ce),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .wdata     (wdata),
        .wpush     (wpush),
        .wfull     (wfull)
    );

    always #5 clk = ~clk;

    // Memory word w holds 0x60+w, so word 0x40 reads 0xA0.
    always @(posedge clk) if (mem_ce) mem_rdata <= DATA_W'(32'h60) + DATA_W'(mem_addr);

    typedef struct {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
        int          ss;
        int          sl;
        bit          rnd;
        int          exp_beats;
        int          exp_issues;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t               vecs[11];
    beat_t              exp_q[$];
    logic [MEM_AW-1:0]  exp_addr_q[$];
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 cyc = 0;
    int                 pushes_seen = 0;
    int                 ces_seen = 0;
    int                 first_ce_cyc = -1;
    int                 first_push_cyc = -1;
    logic [1:0]         last_resp = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_ce) begin
                ces_seen++;
                if (first_ce_cyc < 0) first_ce_cyc = cyc;
                if (exp_addr_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_mem_ce: got addr %h expected no access", mem_addr);
                end else begin
                    chk("mem_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
                end
            end
            if (wpush) begin
                chk("push_while_full", 64'(wfull), 64'(0));
                if (first_push_cyc < 0) first_push_cyc = cyc;
                last_resp = wdata[2:1];
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_push: got %h expected none", wdata);
                end else begin
                    chk("beat", 64'(wdata), 64'(exp_q.pop_front()));
                end
                pushes_seen++;
            end
        end
    end

    function automatic bit vec_ok(input vec_t v);
        if (v.burst == 2'b00 || v.burst == 2'b01) return 1'b1;
`ifdef RD_WRAP_BURST_EN
        if (v.burst == 2'b10 && (v.len == 4'd1 || v.len == 4'd3 || v.len == 4'd7 || v.len == 4'd15))
            return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_addr(input vec_t v, input int i);
        logic [31:0] win, base;
        case (v.burst)
            2'b00:   return v.addr;
            2'b01:   return v.addr + 32'(4 * i);
            default: begin
                win  = (32'(v.len) + 32'd1) * 32'd4;
                base = v.addr - (v.addr % win);
                return base + ((v.addr - base + 32'(4 * i)) % win);
            end
        endcase
    endfunction

    task automatic start_req(input vec_t v, output int hs);
        beat_t       b;
        logic [31:0] a;
        bit          ok;
        int          k;
        ok = vec_ok(v);
        for (int i = 0; i <= int'(v.len); i++) begin
            b.rid   = v.id;
            b.rlast = (i == int'(v.len));
            if (ok) begin
                a = model_addr(v, i);
                exp_addr_q.push_back(a[15:2]);
                b.rdata = 32'h60 + 32'(a[15:2]);
                b.rresp = 2'b00;
            end else begin
                b.rdata = '0;
                b.rresp = 2'b10;
            end
            exp_q.push_back(b);
        end
        pushes_seen = 0; ces_seen = 0; first_ce_cyc = -1; first_push_cyc = -1;
        k = 0;
        while (!ar_if.ARREADY && k < 50) begin
            @(posedge clk); #1; k++;
        end
        chk("arready_before_req", 64'(ar_if.ARREADY), 64'(1));
        ar_if.ARID = v.id; ar_if.ARADDR = v.addr; ar_if.ARLEN = v.len;
        ar_if.ARBURST = v.burst; ar_if.ARVALID = 1'b1;
        @(posedge clk); #1;
        hs = cyc;
        ar_if.ARVALID = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int hs;
        start_req(v, hs);
        for (int k = 0; k < 300; k++) begin
            wfull = v.rnd ? ($urandom_range(0, 2) == 0) : (k >= v.ss && k < v.ss + v.sl);
            @(posedge clk); #1;
            if (pushes_seen >= v.exp_beats && k >= v.ss + v.sl) break;
        end
        wfull = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_pushes"}, 64'(pushes_seen), 64'(v.exp_beats));
        chk({name, "_issues"}, 64'(ces_seen), 64'(v.exp_issues));
        chk({name, "_rresp"}, 64'(last_resp), 64'(v.exp_resp));
        chk({name, "_left"}, 64'(exp_q.size() + exp_addr_q.size()), 64'(0));
        chk({name, "_arready_after"}, 64'(ar_if.ARREADY), 64'(1));
        if (vec_ok(v) && !v.rnd && (v.sl == 0 || v.ss >= 2)) begin
            chk({name, "_ce_latency"}, 64'(first_ce_cyc + 1 - hs), 64'(1));
            chk({name, "_push_latency"}, 64'(first_push_cyc + 1 - hs), 64'(2));
        end
        exp_q.delete();
        exp_addr_q.delete();
    endtask

    initial begin
        vec_t v;
        int   hs;
        vecs[0] = '{id:8'h12, addr:32'h100, len:4'd3, burst:2'b01, ss:0, sl:0, rnd:0,
                    exp_beats:4, exp_issues:4, exp_resp:2'b00};
        vecs[1] = '{id:8'h12, addr:32'h100, len:4'd3, burst:2'b01, ss:2, sl:3, rnd:0,
                    exp_beats:4, exp_issues:4, exp_resp:2'b00};
        vecs[2] = '{id:8'h34, addr:32'h20, len:4'd2, burst:2'b00, ss:0, sl:0, rnd:0,
                    exp_beats:3, exp_issues:3, exp_resp:2'b00};
        vecs[3] = '{id:8'h56, addr:32'h0, len:4'd1, burst:2'b11, ss:0, sl:0, rnd:0,
                    exp_beats:2, exp_issues:0, exp_resp:2'b10};
`ifdef RD_WRAP_BURST_EN
        vecs[4] = '{id:8'h78, addr:32'h38, len:4'd3, burst:2'b10, ss:0, sl:0, rnd:0,
                    exp_beats:4, exp_issues:4, exp_resp:2'b00};
        vecs[10] = '{id:8'hA5, addr:32'h5C, len:4'd7, burst:2'b10, ss:3, sl:2, rnd:0,
                     exp_beats:8, exp_issues:8, exp_resp:2'b00};
`else
        vecs[4] = '{id:8'h78, addr:32'h38, len:4'd3, burst:2'b10, ss:0, sl:0, rnd:0,
                    exp_beats:4, exp_issues:0, exp_resp:2'b10};
        vecs[10] = '{id:8'hA5, addr:32'h5C, len:4'd7, burst:2'b10, ss:3, sl:2, rnd:0,
                     exp_beats:8, exp_issues:0, exp_resp:2'b10};
`endif
        vecs[5] = '{id:8'h9C, addr:32'hFFFF_FFF8, len:4'd15, burst:2'b01, ss:0, sl:0, rnd:1,
                    exp_beats:16, exp_issues:16, exp_resp:2'b00};
        vecs[6] = '{id:8'h3F, addr:32'h404, len:4'd0, burst:2'b01, ss:0, sl:0, rnd:0,
                    exp_beats:1, exp_issues:1, exp_resp:2'b00};
        vecs[7] = '{id:8'h21, addr:32'h40, len:4'd2, burst:2'b10, ss:0, sl:0, rnd:0,
                    exp_beats:3, exp_issues:0, exp_resp:2'b10};
        vecs[8] = '{id:8'h45, addr:32'h80, len:4'd0, burst:2'b00, ss:1, sl:2, rnd:0,
                    exp_beats:1, exp_issues:1, exp_resp:2'b00};
        vecs[9] = '{id:8'h66, addr:32'h0, len:4'd3, burst:2'b11, ss:1, sl:2, rnd:0,
                    exp_beats:4, exp_issues:0, exp_resp:2'b10};

        ar_if.ARID = '0; ar_if.ARADDR = '0; ar_if.ARLEN = '0;
        ar_if.ARBURST = '0; ar_if.ARVALID = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", 64'(ar_if.ARREADY), 64'(0));
        chk("rst_mem_ce", 64'(mem_ce), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_wpush", 64'(wpush), 64'(0));
        chk("rst_wdata", 64'(wdata), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arready_after_rst", 64'(ar_if.ARREADY), 64'(1));

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of an 8-beat burst, right as the second beat is pushed.
        v = '{id:8'h9A, addr:32'h200, len:4'd7, burst:2'b01, ss:0, sl:0, rnd:0,
              exp_beats:8, exp_issues:8, exp_resp:2'b00};
        start_req(v, hs);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (pushes_seen >= 2) break;
        end
        chk("abort_pushes_before", 64'(pushes_seen), 64'(2));
        rst_n = 1'b0;
        #1;
        chk("abort_wpush", 64'(wpush), 64'(0));
        chk("abort_arready", 64'(ar_if.ARREADY), 64'(0));
        chk("abort_mem_ce", 64'(mem_ce), 64'(0));
        chk("abort_wdata", 64'(wdata), 64'(0));
        exp_q.delete();
        exp_addr_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_arready_release", 64'(ar_if.ARREADY), 64'(1));
        v = '{id:8'hC3, addr:32'h10, len:4'd0, burst:2'b01, ss:0, sl:0, rnd:0,
              exp_beats:1, exp_issues:1, exp_resp:2'b00};
        run_vec(v, "post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
